alu_seq: RTL

- Parametrised, handshaked, multi-cycle ALU; next generation of the CPU's 4-bit opcode ALU.
- Generalised to WIDTH bits, with a valid/ready interface, status flags, a double-width multiply and iterative shifts/rotates.
- Sits between the decode/issue stage (upstream) and writeback (downstream) of the nibble CPU datapath.

---
 rtl/alu_pkg.sv | 40 ++++
 rtl/alu_mul_iter.sv | 57 +++++
 rtl/alu_seq.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared types and helpers for the sequential ALU.
// ALU_SEQ_BARREL_SHIFT_EN: shifts and rotates finish in a single cycle.
package alu_pkg;

    typedef enum logic [3:0] {
        OP_ADD = 4'h0, OP_SUB = 4'h1, OP_MUL = 4'h2, OP_NEG = 4'h3,
        OP_AND = 4'h4, OP_OR  = 4'h5, OP_XOR = 4'h6, OP_NOR = 4'h7,
        OP_SLL = 4'h8, OP_SRL = 4'h9, OP_ROL = 4'hA, OP_SWP = 4'hB,
        OP_SRA = 4'hC, OP_ROR = 4'hD
    } op_e;

    typedef struct packed {
        logic z;
        logic n;
        logic c;
        logic v;
    } flags_t;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

    function automatic logic is_shift(input op_e op);
        return op inside {OP_SLL, OP_SRL, OP_SRA, OP_ROL, OP_ROR};
    endfunction

    function automatic logic is_rotate(input op_e op);
        return op inside {OP_ROL, OP_ROR};
    endfunction

    // A zero effective shift count collapses to the single-cycle path.
    function automatic logic is_multicycle(input op_e op, input logic zero_count);
        logic shift_iter;
`ifdef ALU_SEQ_BARREL_SHIFT_EN
        shift_iter = 1'b0;
`else
        shift_iter = is_shift(op) && !zero_count;
`endif
        return (op == OP_MUL) || shift_iter;
    endfunction

endpackage

// File: rtl/alu_mul_iter.sv
// Shift-add unsigned multiplier, one multiplier bit per cycle.
// The first step happens on the start edge so done pulses WIDTH-1 cycles later.
module alu_mul_iter #(
    parameter int WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   prod
);
    localparam int CNT_W = $clog2(WIDTH) + 1;

    logic [WIDTH-1:0]   mcand_q;
    logic [2*WIDTH-1:0] prod_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               busy_q;
    logic               done_q;

    // prod holds {partial sum, remaining multiplier bits}
    function automatic logic [2*WIDTH-1:0] mul_step(input logic [WIDTH-1:0] mc,
                                                    input logic [2*WIDTH-1:0] p);
        logic [WIDTH:0] sum;
        sum = {1'b0, p[2*WIDTH-1:WIDTH]} + (p[0] ? {1'b0, mc} : '0);
        return {sum, p[WIDTH-1:1]};
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (start) begin
                mcand_q <= a;
                prod_q  <= mul_step(a, {{WIDTH{1'b0}}, b});
                cnt_q   <= CNT_W'(WIDTH - 1);
                busy_q  <= 1'b1;
            end else if (busy_q) begin
                prod_q <= mul_step(mcand_q, prod_q);
                cnt_q  <= cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    busy_q <= 1'b0;
                    done_q <= 1'b1;
                end
            end
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign prod = prod_q;

endmodule

// File: rtl/alu_seq.sv
// Handshaked multi-cycle ALU: IDLE -> (BUSY) -> DONE, registered result and flags.
// ALU_SEQ_BARREL_SHIFT_EN: replaces iterative shifts/rotates with a barrel shifter.
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH   = 4,
    parameter int SHAMT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] res,
    output logic [WIDTH-1:0] res_hi,
    output logic [3:0]       flags,
    output logic             err
);
    localparam int MSB = WIDTH - 1;
    localparam logic [WIDTH-1:0] W_B = WIDTH'(WIDTH);

    op_e                 op_in;
    state_e              state_q;
    op_e                 op_q;
    logic [WIDTH-1:0]    a_q, b_q, sh_q;
    logic [SHAMT_W-1:0]  cnt_q;
    logic                b_gt_q;
    logic [WIDTH-1:0]    res_q, res_hi_q;
    flags_t              flags_q;
    logic                err_q;

    logic                accept;
    logic [SHAMT_W-1:0]  n_in;
    logic                b_gt;
    logic [WIDTH:0]      sum_w;
    logic [WIDTH-1:0]    sc_res;
    logic                sc_c, sc_v, sc_err;
    logic                step_c;
    logic [WIDTH-1:0]    step_v;
    logic                mul_start, mul_busy, mul_done, mul_v;
    logic [2*WIDTH-1:0]  mul_prod;
    logic signed [WIDTH-1:0] mul_hi_s;

    // Returns {bit leaving the word, shifted word} for one step.
    function automatic logic [WIDTH:0] shift_step(input op_e o, input logic [WIDTH-1:0] v);
        case (o)
            OP_SLL:  return {v, 1'b0};
            OP_ROL:  return {v[MSB], v[MSB-1:0], v[MSB]};
            OP_SRL:  return {v[0], 1'b0, v[MSB:1]};
            OP_SRA:  return {v[0], v[MSB], v[MSB:1]};
            OP_ROR:  return {v[0], v[0], v[MSB:1]};
            default: return {1'b0, v};
        endcase
    endfunction

    function automatic flags_t mk_flags(input logic [WIDTH-1:0] r, input logic c, input logic v);
        return '{z: (r == '0), n: r[MSB], c: c, v: v};
    endfunction

    assign op_in     = op_e'(op);
    assign accept    = in_valid && (state_q == IDLE);
    assign mul_start = accept && (op_in == OP_MUL) && !mul_busy;

    always_comb begin
        n_in = SHAMT_W'(WIDTH);
        b_gt = 1'b0;
        if (is_rotate(op_in)) begin
            n_in = SHAMT_W'(b % W_B);
        end else if (b > W_B) begin
            b_gt = 1'b1;
        end else begin
            n_in = SHAMT_W'(b);
        end
    end

`ifdef ALU_SEQ_BARREL_SHIFT_EN
    logic [WIDTH:0]          sll_w, srl_w;
    logic signed [WIDTH:0]   sra_w;
    logic [2*WIDTH-1:0]      rol_w, ror_w;
    logic [WIDTH-1:0]        bs_res;
    logic                    bs_c;

    // Extra guard bit on each shift captures the last bit shifted out.
    always_comb begin
        sll_w  = {1'b0, a} << n_in;
        srl_w  = {a, 1'b0} >> n_in;
        sra_w  = $signed({a, 1'b0}) >>> n_in;
        rol_w  = {a, a} << n_in;
        ror_w  = {a, a} >> n_in;
        bs_res = a;
        bs_c   = 1'b0;
        case (op_in)
            OP_SLL: begin bs_res = sll_w[WIDTH-1:0];       bs_c = sll_w[WIDTH]; end
            OP_SRL: begin bs_res = srl_w[WIDTH:1];         bs_c = srl_w[0];     end
            OP_SRA: begin bs_res = sra_w[WIDTH:1];         bs_c = sra_w[0];     end
            OP_ROL: begin bs_res = rol_w[2*WIDTH-1:WIDTH]; bs_c = (n_in != '0) && rol_w[WIDTH]; end
            OP_ROR: begin bs_res = ror_w[WIDTH-1:0];       bs_c = (n_in != '0) && ror_w[MSB];   end
            default: ;
        endcase
        if (b_gt) bs_c = 1'b0;
    end
`endif

    always_comb begin
        sum_w  = {1'b0, a} + {1'b0, b};
        sc_res = '0;
        sc_c   = 1'b0;
        sc_v   = 1'b0;
        sc_err = 1'b0;
        case (op_in)
            OP_ADD: begin
                sc_res = sum_w[WIDTH-1:0];
                sc_c   = sum_w[WIDTH];
                sc_v   = (a[MSB] == b[MSB]) && (sum_w[MSB] != a[MSB]);
            end
            OP_SUB: begin
                sc_res = a - b;
                sc_c   = a < b;
                sc_v   = (a[MSB] != b[MSB]) && (sc_res[MSB] != a[MSB]);
            end
            OP_NEG: begin
                sc_res = -a;
                sc_v   = (a == {1'b1, {(WIDTH-1){1'b0}}});
            end
            OP_MUL: ;
            OP_AND: sc_res = a & b;
            OP_OR:  sc_res = a | b;
            OP_XOR: sc_res = a ^ b;
            OP_NOR: sc_res = ~(a | b);
            OP_SWP: sc_res = {a[WIDTH/2-1:0], a[WIDTH-1:WIDTH/2]};
            OP_SLL, OP_SRL, OP_SRA, OP_ROL, OP_ROR: begin
`ifdef ALU_SEQ_BARREL_SHIFT_EN
                sc_res = bs_res;
                sc_c   = bs_c;
`else
                sc_res = a;
`endif
            end
            default: sc_err = 1'b1;
        endcase
    end

    assign {step_c, step_v} = shift_step(op_q, sh_q);

    // Signed high half of a*b, derived from the unsigned product.
    assign mul_hi_s = mul_prod[2*WIDTH-1:WIDTH] - (a_q[MSB] ? b_q : '0) - (b_q[MSB] ? a_q : '0);
    assign mul_v    = mul_hi_s != {WIDTH{mul_prod[MSB]}};

    alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
        .clk   (clk),
        .rst   (rst),
        .start (mul_start),
        .a     (a),
        .b     (b),
        .busy  (mul_busy),
        .done  (mul_done),
        .prod  (mul_prod)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            res_q    <= '0;
            res_hi_q <= '0;
            flags_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (accept) begin
                    op_q   <= op_in;
                    a_q    <= a;
                    b_q    <= b;
                    sh_q   <= a;
                    cnt_q  <= n_in;
                    b_gt_q <= b_gt;
                    if (is_multicycle(op_in, n_in == '0)) begin
                        state_q <= BUSY;
                    end else begin
                        state_q  <= DONE;
                        res_q    <= sc_res;
                        res_hi_q <= '0;
                        flags_q  <= sc_err ? flags_t'('0) : mk_flags(sc_res, sc_c, sc_v);
                        err_q    <= sc_err;
                    end
                end
                BUSY: if (op_q == OP_MUL) begin
                    if (mul_done) begin
                        state_q  <= DONE;
                        res_q    <= mul_prod[MSB:0];
                        res_hi_q <= mul_prod[2*WIDTH-1:WIDTH];
                        flags_q  <= mk_flags(mul_prod[MSB:0], |mul_prod[2*WIDTH-1:WIDTH], mul_v);
                        err_q    <= 1'b0;
                    end
                end else begin
                    sh_q  <= step_v;
                    cnt_q <= cnt_q - SHAMT_W'(1);
                    if (cnt_q == SHAMT_W'(1)) begin
                        state_q  <= DONE;
                        res_q    <= step_v;
                        res_hi_q <= '0;
                        flags_q  <= mk_flags(step_v, step_c && !b_gt_q, 1'b0);
                        err_q    <= 1'b0;
                    end
                end
                DONE: if (out_ready) state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign res       = res_q;
    assign res_hi    = res_hi_q;
    assign flags     = flags_q;
    assign err       = err_q;

endmodule
